// File: rtl/hazard_ctrl_if.sv
// Pipeline/hazard-controller bundle: D-stage operand fields in, stall/flush/forward controls out.
// Latency: none, plain wires between the pipeline and the controller.
// Backpressure: stalls travel as level signals in this bundle; there is no handshake.
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           Rs1D;
    logic [4:0]           Rs2D;
    logic [4:0]           RdD;
    logic                 RegWriteD;
    logic                 ResultSrcD;
    logic                 PCsrcE;
    logic                 StallF;
    logic                 StallD;
    logic                 StallE;
    logic                 StallM;
    logic                 FlushD;
    logic                 FlushE;
    logic                 FlushW;
    logic [1:0]           ForwardAE;
    logic [1:0]           ForwardBE;
    logic                 BypassD1;
    logic                 BypassD2;
    logic [CNT_WIDTH-1:0] StallCnt;
    logic [CNT_WIDTH-1:0] FlushCnt;

    // Pipeline side: presents the D/E information and consumes the controls.
    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCsrcE,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, BypassD1, BypassD2, StallCnt, FlushCnt
    );

    // Controller side.
    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCsrcE,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, BypassD1, BypassD2, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: shadow E/M/W pipe, forwarding, load-use/branch/memory-wait control.
// Latency: all controls are combinational from shadow state and D/E inputs (0 cycles).
// Backpressure: drives StallF/D/E/M to hold pipeline registers; HAZARD_PERF_EN builds the stall/flush counters.
module hazard_ctrl #(
    parameter int MEM_LAT   = 0,
    parameter int CNT_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] LU_STALL = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    localparam bit         HAS_WAIT  = (MEM_LAT > 0);
    localparam logic [3:0] WAIT_INIT = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } stg_t;

    typedef struct packed {
        stg_t       ctl;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } stg_e_t;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_nxt;
    stg_e_t     r_e;
    stg_t       r_m;
    stg_t       r_w;

    logic w_in_run;
    logic w_mem_wait;
    logic w_lu_haz;
    logic w_br_flush;
    logic w_lu_stall;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic w_flush_d, w_flush_e, w_flush_w;
    logic [1:0] w_fwd_a, w_fwd_b;
    logic w_byp_1, w_byp_2;
    logic w_unused_w_load;

    // M has priority over W; x0 never matches because rd must be nonzero.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input stg_t m, input stg_t w);
        if (m.regwrite && (m.rd != 5'd0) && (m.rd == rs)) return 2'b10;
        if (w.regwrite && (w.rd != 5'd0) && (w.rd == rs)) return 2'b01;
        return 2'b00;
    endfunction

    assign w_in_run   = (r_state == RUN);
    assign w_mem_wait = (r_state == MEM_WAIT);
    assign w_lu_haz   = r_e.ctl.load && (r_e.ctl.rd != 5'd0) &&
                        ((r_e.ctl.rd == bus.Rs1D) || (r_e.ctl.rd == bus.Rs2D));
    assign w_br_flush = w_in_run && bus.PCsrcE;
    // A taken branch squashes the dependent instruction, so it wins over the load-use stall.
    assign w_lu_stall = w_in_run && !bus.PCsrcE && w_lu_haz;

    // Stall/flush decode: reset forces bubbles, memory wait freezes F..M, then branch, then load-use.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (rst) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_mem_wait) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (w_br_flush) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lu_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    assign w_fwd_a = rst ? 2'b00 : fwd_sel(r_e.rs1, r_m, r_w);
    assign w_fwd_b = rst ? 2'b00 : fwd_sel(r_e.rs2, r_m, r_w);
    assign w_byp_1 = !rst && r_w.regwrite && (r_w.rd != 5'd0) && (r_w.rd == bus.Rs1D);
    assign w_byp_2 = !rst && r_w.regwrite && (r_w.rd != 5'd0) && (r_w.rd == bus.Rs2D);

    // Next-state: a load leaving E always enters M in RUN, so that edge starts the memory wait.
    // The wait takes precedence over LU_STALL; the load-use outputs still fire this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (HAS_WAIT && r_e.ctl.load) begin
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = WAIT_INIT;
                end else if (w_lu_stall) begin
                    w_state_nxt = LU_STALL;
                end
            end
            LU_STALL: w_state_nxt = RUN;
            MEM_WAIT: begin
                if (r_wait_cnt == 4'd0) w_state_nxt = RUN;
                else                    w_wait_nxt  = r_wait_cnt - 4'd1;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // State, wait counter and shadow pipeline advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= 4'd0;
            r_e        <= '0;
            r_m        <= '0;
            r_w        <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (!w_stall_e) begin
                if (w_flush_e) r_e <= '0;
                else           r_e <= '{ctl: '{rd: bus.RdD, regwrite: bus.RegWriteD, load: bus.ResultSrcD},
                                        rs1: bus.Rs1D, rs2: bus.Rs2D};
            end
            if (!w_stall_m) r_m <= r_e.ctl;
            r_w <= w_flush_w ? '0 : r_m;
        end
    end

    // W only needs rd/regwrite; the load flag rides along to keep the stage layout uniform.
    assign w_unused_w_load = r_w.load;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    // Count fetch-stall cycles and branch-caused E flushes; both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_f)  r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_br_flush) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign bus.StallCnt = r_stall_cnt;
    assign bus.FlushCnt = r_flush_cnt;
`else
    assign bus.StallCnt = '0;
    assign bus.FlushCnt = '0;
`endif

    assign bus.StallF    = w_stall_f;
    assign bus.StallD    = w_stall_d;
    assign bus.StallE    = w_stall_e;
    assign bus.StallM    = w_stall_m;
    assign bus.FlushD    = w_flush_d;
    assign bus.FlushE    = w_flush_e;
    assign bus.FlushW    = w_flush_w;
    assign bus.ForwardAE = w_fwd_a;
    assign bus.ForwardBE = w_fwd_b;
    assign bus.BypassD1  = w_byp_1;
    assign bus.BypassD2  = w_byp_2;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: MEM_LAT=0 instance for forwarding/stall/flush, MEM_LAT=3 instance for memory wait.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-derived from the pipeline walk-through of each directed step.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic d_rw, d_ld, d_pc;

    int n_vec = 0;
    int n_err = 0;

    // Control vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [31:0] C_NONE = 32'b0000000;
    localparam logic [31:0] C_LU   = 32'b1100010;
    localparam logic [31:0] C_BR   = 32'b0000110;
    localparam logic [31:0] C_RST  = 32'b0000110;
    localparam logic [31:0] C_MW   = 32'b1111001;
`ifdef HAZARD_PERF_EN
    localparam logic [31:0] EXP_SCNT = 32'd2;
    localparam logic [31:0] EXP_FCNT = 32'd1;
`else
    localparam logic [31:0] EXP_SCNT = 32'd0;
    localparam logic [31:0] EXP_FCNT = 32'd0;
`endif

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_WIDTH(32)) if0 ();
    hazard_ctrl_if #(.CNT_WIDTH(32)) if3 ();

    assign if0.Rs1D = d_rs1;  assign if3.Rs1D = d_rs1;
    assign if0.Rs2D = d_rs2;  assign if3.Rs2D = d_rs2;
    assign if0.RdD  = d_rd;   assign if3.RdD  = d_rd;
    assign if0.RegWriteD  = d_rw;  assign if3.RegWriteD  = d_rw;
    assign if0.ResultSrcD = d_ld;  assign if3.ResultSrcD = d_ld;
    assign if0.PCsrcE     = d_pc;  assign if3.PCsrcE     = d_pc;

    hazard_ctrl #(.MEM_LAT(0), .CNT_WIDTH(32)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    hazard_ctrl #(.MEM_LAT(3), .CNT_WIDTH(32)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic [6:0] ctl0, ctl3;
    logic [3:0] fwd0, fwd3;
    logic [1:0] byp0, byp3;
    assign ctl0 = {if0.StallF, if0.StallD, if0.StallE, if0.StallM, if0.FlushD, if0.FlushE, if0.FlushW};
    assign ctl3 = {if3.StallF, if3.StallD, if3.StallE, if3.StallM, if3.FlushD, if3.FlushE, if3.FlushW};
    assign fwd0 = {if0.ForwardAE, if0.ForwardBE};
    assign fwd3 = {if3.ForwardAE, if3.ForwardBE};
    assign byp0 = {if0.BypassD1, if0.BypassD2};
    assign byp3 = {if3.BypassD1, if3.BypassD2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic pc);
        d_rs1 = rs1; d_rs2 = rs2; d_rd = rd; d_rw = rw; d_ld = ld; d_pc = pc;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        // Reset cycle with hazard-looking inputs: outputs must still be the reset values.
        rst = 1'b1;
        drv(5, 5, 5, 1, 1, 1);
        smp;
        chk("rst_ctl",  32'(ctl0), C_RST);
        chk("rst_fwd",  32'(fwd0), 'b0);
        chk("rst_byp",  32'(byp0), 'b0);
        chk("rst_scnt", if0.StallCnt, 'd0);
        chk("rst_fcnt", if0.FlushCnt, 'd0);
        nxt; rst = 1'b0;

        // lw x5 ; add x6,x5,x1 ; or x8,x5,x9
        drv(2, 0, 5, 1, 1, 0); smp; chk("lw_d_ctl", 32'(ctl0), C_NONE);
        nxt; drv(5, 1, 6, 1, 0, 0); smp;
        chk("lu_ctl", 32'(ctl0), C_LU);
        chk("lu_fwd", 32'(fwd0), 'b0);
        nxt; smp;
        chk("lu_once_ctl", 32'(ctl0), C_NONE);
        chk("lu_bubble_fwd", 32'(fwd0), 'b0);
        nxt; drv(5, 9, 8, 1, 0, 0); smp;
        chk("lu_fwd_w", 32'(fwd0), 'b0100);
        chk("lu_byp", 32'(byp0), 'b10);
        chk("lu_run_ctl", 32'(ctl0), C_NONE);
        nxt; drv(0, 0, 0, 0, 0, 0); smp;
        chk("fwd_clear", 32'(fwd0), 'b0);

        // add x5 ; sub x7,x5,x5 ; and x9,x5,x3
        nxt; drv(1, 2, 5, 1, 0, 0); smp;
        nxt; drv(5, 5, 7, 1, 0, 0); smp;
        chk("alu_no_stall", 32'(ctl0), C_NONE);
        nxt; drv(5, 3, 9, 1, 0, 0); smp;
        chk("fwd_m_both", 32'(fwd0), 'b1010);
        chk("fwd_m_byp", 32'(byp0), 'b0);
        nxt; drv(0, 0, 0, 0, 0, 0); smp;
        chk("fwd_w_next", 32'(fwd0), 'b0100);

        // add x4 ; add x4,x4,x0 ; xor x10,x4,x4  (x0 operand, then M and W both match)
        nxt; drv(1, 1, 4, 1, 0, 0); smp;
        nxt; drv(4, 0, 4, 1, 0, 0); smp;
        chk("fwd_none", 32'(fwd0), 'b0);
        nxt; drv(4, 4, 10, 1, 0, 0); smp;
        chk("fwd_x0_src", 32'(fwd0), 'b1000);
        nxt; drv(0, 0, 0, 0, 0, 0); smp;
        chk("fwd_m_over_w", 32'(fwd0), 'b1010);

        // Taken branch in the same cycle as a load-use hazard
        nxt; drv(2, 0, 5, 1, 1, 0); smp;
        nxt; drv(5, 1, 6, 1, 0, 1); smp;
        chk("br_lu_ctl", 32'(ctl0), C_BR);
        nxt; drv(5, 5, 11, 1, 0, 0); smp;
        chk("br_after_ctl", 32'(ctl0), C_NONE);
        chk("br_after_byp", 32'(byp0), 'b0);
        nxt; drv(0, 0, 0, 0, 0, 0); smp;
        chk("br_load_adv", 32'(fwd0), 'b0101);

        // Load to x0: no stall, no forward, no bypass
        nxt; drv(2, 0, 0, 1, 1, 0); smp;
        nxt; drv(0, 0, 6, 1, 0, 0); smp;
        chk("x0_no_stall", 32'(ctl0), C_NONE);
        nxt; drv(0, 0, 0, 0, 0, 0); smp;
        chk("x0_no_fwd", 32'(fwd0), 'b0);
        nxt; smp;
        chk("x0_no_byp", 32'(byp0), 'b0);

        // MEM_LAT=3: lw x5 ; add x6,x5,x1
        nxt; rst = 1'b1; drv(0, 0, 0, 0, 0, 0); smp;
        chk("m3_rst_ctl", 32'(ctl3), C_RST);
        nxt; rst = 1'b0; drv(2, 0, 5, 1, 1, 0); smp;
        chk("m3_lw_ctl", 32'(ctl3), C_NONE);
        nxt; drv(5, 1, 6, 1, 0, 0); smp;
        chk("m3_lu_ctl", 32'(ctl3), C_LU);
        for (int k = 0; k < 3; k++) begin
            nxt; smp;
            chk("m3_wait_ctl", 32'(ctl3), C_MW);
            chk("m3_wait_byp", 32'(byp3), 'b0);
        end
        nxt; smp;
        chk("m3_wait_end", 32'(ctl3), C_NONE);
        nxt; drv(5, 0, 3, 1, 1, 0); smp;
        chk("m3_m_held_fwd", 32'(fwd3), 'b0100);
        chk("m3_m_held_byp", 32'(byp3), 'b10);
        chk("m3_run_ctl", 32'(ctl3), C_NONE);
        nxt; drv(0, 0, 0, 0, 0, 0); smp;
        chk("m3_lw2_ctl", 32'(ctl3), C_NONE);
        nxt; smp;
        chk("m3_wait2_ctl", 32'(ctl3), C_MW);
        nxt; rst = 1'b1; smp;
        chk("m3_rst_mid", 32'(ctl3), C_RST);
        nxt; rst = 1'b0; smp;
        chk("m3_rst_abandon", 32'(ctl3), C_NONE);

        // Counters: two load-use stalls and one taken branch since the last reset
        nxt; drv(2, 0, 5, 1, 1, 0); smp;
        nxt; drv(5, 1, 6, 1, 0, 0); smp;
        chk("pc_lu1", 32'(ctl0), C_LU);
        nxt; smp;
        nxt; drv(1, 0, 7, 1, 1, 0); smp;
        nxt; drv(0, 7, 8, 1, 0, 0); smp;
        chk("pc_lu2", 32'(ctl0), C_LU);
        nxt; smp;
        nxt; drv(0, 0, 0, 0, 0, 1); smp;
        chk("pc_br", 32'(ctl0), C_BR);
        nxt; drv(0, 0, 0, 0, 0, 0); smp;
        chk("pc_scnt", if0.StallCnt, EXP_SCNT);
        chk("pc_fcnt", if0.FlushCnt, EXP_FCNT);
        nxt; rst = 1'b1; smp;
        nxt; rst = 1'b0; smp;
        chk("pc_rst_scnt", if0.StallCnt, 'd0);
        chk("pc_rst_fcnt", if0.FlushCnt, 'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
